// File: rtl/full_adder_checker.sv
// Response checker for a 1-bit full adder.
// Waits for each new {a,b,cin} vector to stay stable for SETTLE_CYCLES edges,
// then compares the observed sum/cout against the ideal result and keeps
// pass/error statistics, a sticky error flag, the first failing vector and a
// coverage map of the checked vectors.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   en              checking enable (0 forces IDLE, statistics held)
//   clr             synchronous clear of statistics and coverage
//   a, b, cin       adder inputs as applied to the DUT
//   sum, cout       DUT outputs
//   check_pulse     one-cycle strobe for a completed comparison
//   mismatch        result of the last comparison (1 = fail)
//   err_flag        sticky failure flag
//   first_err_vec   {a,b,cin,sum,cout} of the first failing check
//   pass_cnt        saturating count of passing checks
//   err_cnt         saturating count of failing checks
//   cov_map         bit {a,b,cin} set once that vector has been checked
//   done            high while every vector has been covered
module full_adder_checker #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             a,
  input  logic             b,
  input  logic             cin,
  input  logic             sum,
  input  logic             cout,
  output logic             check_pulse,
  output logic             mismatch,
  output logic             err_flag,
  output logic [4:0]       first_err_vec,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [7:0]       cov_map,
  output logic             done
);

  localparam int unsigned          SC_W        = 4;
  localparam logic [SC_W-1:0]      SETTLE_LAST = SC_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]     CNT_MAX     = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    WAIT   = 2'd3
  } state_t;

  state_t          state;
  logic [SC_W-1:0] cnt;
  logic [2:0]      vec_q;
  logic            sum_q;
  logic            cout_q;

  logic [2:0]      vec_c;
  logic            chg_c;
  logic            exp_sum_c;
  logic            exp_cout_c;
  logic            fail_c;

  assign vec_c = {a, b, cin};
  assign chg_c = (vec_c != vec_q);

  // Ideal adder response for the registered (settled) vector
  assign exp_sum_c  = vec_q[2] ^ vec_q[1] ^ vec_q[0];
  assign exp_cout_c = (vec_q[2] & vec_q[1]) | (vec_q[2] & vec_q[0]) | (vec_q[1] & vec_q[0]);
  assign fail_c     = (sum_q != exp_sum_c) || (cout_q != exp_cout_c);

  assign done = (cov_map == 8'hFF);

  // Settle/check sequencer and statistics
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      vec_q         <= 3'b000;
      sum_q         <= 1'b0;
      cout_q        <= 1'b0;
      check_pulse   <= 1'b0;
      mismatch      <= 1'b0;
      err_flag      <= 1'b0;
      first_err_vec <= 5'b00000;
      pass_cnt      <= '0;
      err_cnt       <= '0;
      cov_map       <= 8'h00;
    end else begin
      vec_q       <= vec_c;
      sum_q       <= sum;
      cout_q      <= cout;
      check_pulse <= 1'b0;

      if (!en) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            // The vector present at enable is treated as new
            state <= SETTLE;
            cnt   <= '0;
          end
          SETTLE: begin
            if (chg_c) begin
              cnt <= '0;
            end else if (cnt == SETTLE_LAST) begin
              state <= CHECK;
            end else begin
              cnt <= cnt + SC_W'(1);
            end
          end
          CHECK: begin
            check_pulse <= 1'b1;
            mismatch    <= fail_c;
            cov_map[vec_q] <= 1'b1;
            if (fail_c) begin
              if (err_cnt != CNT_MAX) err_cnt <= err_cnt + CNT_W'(1);
              if (!err_flag) begin
                err_flag      <= 1'b1;
                first_err_vec <= {vec_q, sum_q, cout_q};
              end
            end else if (pass_cnt != CNT_MAX) begin
              pass_cnt <= pass_cnt + CNT_W'(1);
            end
            // A change arriving during CHECK goes straight back to settling
            state <= chg_c ? SETTLE : WAIT;
            cnt   <= '0;
          end
          WAIT: begin
            if (chg_c) begin
              state <= SETTLE;
              cnt   <= '0;
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end

      // Clear overrides any result produced in the same cycle
      if (clr) begin
        mismatch      <= 1'b0;
        err_flag      <= 1'b0;
        first_err_vec <= 5'b00000;
        pass_cnt      <= '0;
        err_cnt       <= '0;
        cov_map       <= 8'h00;
      end
    end
  end

endmodule

// File: tb/tb_full_adder_checker.sv
// Directed bench for full_adder_checker: main instance (CNT_W=8) driven by a
// switchable good/faulty adder model, plus a CNT_W=2 instance for saturation.
module tb_full_adder_checker;

  logic clk;
  logic rst_n;
  logic rst2_n;
  logic en;
  logic clr;
  logic clr2;
  logic a, b, cin;
  logic fault;
  logic sum, cout;
  logic sum_ok, cout_ok;

  logic       check_pulse, mismatch, err_flag, done;
  logic [4:0] first_err_vec;
  logic [7:0] pass_cnt, err_cnt, cov_map;

  logic       check_pulse2, mismatch2, err_flag2, done2;
  logic [4:0] first_err_vec2;
  logic [1:0] pass_cnt2, err_cnt2;
  logic [7:0] cov_map2;

  int n_checks;
  int n_errors;
  int np;
  int fi;

  // Reference adder; fault forces cout stuck at 0
  assign sum_ok  = a ^ b ^ cin;
  assign cout_ok = (a & b) | (a & cin) | (b & cin);
  assign sum     = sum_ok;
  assign cout    = fault ? 1'b0 : cout_ok;

  full_adder_checker #(.SETTLE_CYCLES(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr),
    .a(a), .b(b), .cin(cin), .sum(sum), .cout(cout),
    .check_pulse(check_pulse), .mismatch(mismatch), .err_flag(err_flag),
    .first_err_vec(first_err_vec), .pass_cnt(pass_cnt), .err_cnt(err_cnt),
    .cov_map(cov_map), .done(done)
  );

  full_adder_checker #(.SETTLE_CYCLES(4), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst2_n), .en(en), .clr(clr2),
    .a(a), .b(b), .cin(cin), .sum(sum_ok), .cout(cout_ok),
    .check_pulse(check_pulse2), .mismatch(mismatch2), .err_flag(err_flag2),
    .first_err_vec(first_err_vec2), .pass_cnt(pass_cnt2), .err_cnt(err_cnt2),
    .cov_map(cov_map2), .done(done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Step n falling edges; count check pulses and note the first one's index
  task automatic run(input int n, output int npulse, output int first);
    npulse = 0;
    first  = 0;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (check_pulse) begin
        npulse++;
        if (first == 0) first = i;
      end
    end
  endtask

  task automatic set_vec(input logic [2:0] v);
    {a, b, cin} = v;
  endtask

  function automatic logic maj(input logic [2:0] v);
    return (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]);
  endfunction

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n  = 1'b0;
    rst2_n = 1'b0;
    en     = 1'b0;
    clr    = 1'b0;
    clr2   = 1'b0;
    fault  = 1'b0;
    set_vec(3'b000);

    run(2, np, fi);
    chk_eq("rst_pulse", 32'(check_pulse), 32'd0);
    chk_eq("rst_pass", 32'(pass_cnt), 32'd0);
    chk_eq("rst_err", 32'(err_cnt), 32'd0);
    chk_eq("rst_cov", 32'(cov_map), 32'd0);
    chk_eq("rst_flag", 32'(err_flag), 32'd0);
    chk_eq("rst_done", 32'(done), 32'd0);
    chk_eq("rst_fev", 32'(first_err_vec), 32'd0);
    rst_n  = 1'b1;
    rst2_n = 1'b1;

    run(3, np, fi);
    chk_eq("idle_no_pulse", 32'(np), 32'd0);

    // Good model sweep: one check per vector, 5 cycles after registration
    en = 1'b1;
    for (int v = 0; v < 8; v++) begin
      set_vec(3'(v));
      run(10, np, fi);
      chk_eq($sformatf("sweep_npulse_%0d", v), 32'(np), 32'd1);
      chk_eq($sformatf("sweep_lat_%0d", v), 32'(fi), 32'd6);
    end
    chk_eq("sweep_pass", 32'(pass_cnt), 32'd8);
    chk_eq("sweep_err", 32'(err_cnt), 32'd0);
    chk_eq("sweep_cov", 32'(cov_map), 32'hFF);
    chk_eq("sweep_done", 32'(done), 32'd1);
    chk_eq("sweep_flag", 32'(err_flag), 32'd0);
    chk_eq("sweep_mm", 32'(mismatch), 32'd0);

    clr = 1'b1;
    run(1, np, fi);
    clr = 1'b0;
    chk_eq("clr_pass", 32'(pass_cnt), 32'd0);
    chk_eq("clr_cov", 32'(cov_map), 32'd0);
    chk_eq("clr_done", 32'(done), 32'd0);

    // Faulty model: cout stuck 0 fails wherever the majority is 1
    fault = 1'b1;
    for (int v = 0; v < 8; v++) begin
      set_vec(3'(v));
      run(10, np, fi);
      chk_eq($sformatf("fault_npulse_%0d", v), 32'(np), 32'd1);
      chk_eq($sformatf("fault_mm_%0d", v), 32'(mismatch), 32'(maj(3'(v))));
    end
    chk_eq("fault_pass", 32'(pass_cnt), 32'd4);
    chk_eq("fault_err", 32'(err_cnt), 32'd4);
    chk_eq("fault_flag", 32'(err_flag), 32'd1);
    // First failing vector 011: sum=0, cout=0 (stuck)
    chk_eq("fault_fev", 32'(first_err_vec), 32'b01100);

    clr = 1'b1;
    run(1, np, fi);
    clr   = 1'b0;
    fault = 1'b0;
    chk_eq("clr2_flag", 32'(err_flag), 32'd0);
    chk_eq("clr2_fev", 32'(first_err_vec), 32'd0);
    chk_eq("clr2_err", 32'(err_cnt), 32'd0);

    // Vector toggled faster than the settle window never gets checked
    begin
      int tot;
      tot = 0;
      for (int i = 0; i < 8; i++) begin
        set_vec((i % 2) != 0 ? 3'b010 : 3'b001);
        run(3, np, fi);
        tot += np;
      end
      chk_eq("toggle_no_pulse", 32'(tot), 32'd0);
    end
    set_vec(3'b100);
    run(10, np, fi);
    chk_eq("toggle_hold_npulse", 32'(np), 32'd1);
    chk_eq("toggle_hold_lat", 32'(fi), 32'd6);
    chk_eq("toggle_hold_pass", 32'(pass_cnt), 32'd1);

    // clr coinciding with the check cycle discards the result
    clr = 1'b1;
    run(1, np, fi);
    clr = 1'b0;
    set_vec(3'b110);
    run(5, np, fi);
    chk_eq("clrchk_early", 32'(np), 32'd0);
    clr = 1'b1;
    run(1, np, fi);
    clr = 1'b0;
    chk_eq("clrchk_pulse", 32'(np), 32'd1);
    chk_eq("clrchk_pass", 32'(pass_cnt), 32'd0);
    chk_eq("clrchk_cov", 32'(cov_map), 32'd0);
    set_vec(3'b101);
    run(10, np, fi);
    chk_eq("after_clr_npulse", 32'(np), 32'd1);
    chk_eq("after_clr_pass", 32'(pass_cnt), 32'd1);
    chk_eq("after_clr_cov", 32'(cov_map), 32'h20);

    // Dropping en mid-settle abandons the check and holds statistics
    set_vec(3'b000);
    run(2, np, fi);
    en = 1'b0;
    run(8, np, fi);
    chk_eq("endrop_no_pulse", 32'(np), 32'd0);
    chk_eq("endrop_pass", 32'(pass_cnt), 32'd1);
    chk_eq("endrop_cov", 32'(cov_map), 32'h20);
    en = 1'b1;
    run(10, np, fi);
    chk_eq("reen_npulse", 32'(np), 32'd1);
    chk_eq("reen_lat", 32'(fi), 32'd6);
    chk_eq("reen_pass", 32'(pass_cnt), 32'd2);
    chk_eq("reen_cov", 32'(cov_map), 32'h21);

    // Asynchronous reset mid-settle
    set_vec(3'b011);
    run(2, np, fi);
    rst_n = 1'b0;
    #1;
    chk_eq("arst_pass", 32'(pass_cnt), 32'd0);
    chk_eq("arst_cov", 32'(cov_map), 32'd0);
    chk_eq("arst_pulse", 32'(check_pulse), 32'd0);
    run(2, np, fi);
    chk_eq("arst_no_pulse", 32'(np), 32'd0);
    rst_n = 1'b1;
    run(10, np, fi);
    chk_eq("rel_npulse", 32'(np), 32'd1);
    chk_eq("rel_lat", 32'(fi), 32'd6);
    chk_eq("rel_pass", 32'(pass_cnt), 32'd1);

    // Narrow-counter instance has seen far more than 3 passing checks
    chk_eq("sat_pass", 32'(pass_cnt2), 32'd3);
    chk_eq("sat_err", 32'(err_cnt2), 32'd0);
    chk_eq("sat_done", 32'(done2), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
